// File: rtl/z_staging_queue.sv
// FIFO staging queue for Z results: buffers up to DEPTH captured values and
// publishes them one at a time to a registered output, with bypass, flush and sticky error flags.
module z_staging_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       z_ctrl,
  input  logic [WIDTH-1:0] z_in,
  input  logic             flush,
  output logic [WIDTH-1:0] z_out,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // A single-entry build still needs a 1-bit pointer, so give it a storage index range that matches.
  localparam int MEM_N = (DEPTH > 1) ? DEPTH : 2;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [MEM_N];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] z_out_q, z_out_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_en;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign z_out     = z_out_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    z_out_d     = z_out_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    wr_en       = 1'b0;
    if (flush) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      unique case (z_ctrl)
        2'b10: begin
          if (full) begin
            overflow_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            tail_d  = next_ptr(tail_q);
            count_d = count_q + CW'(1);
          end
        end
        2'b01: begin
          if (empty) begin
            underflow_d = 1'b1;
          end else begin
            z_out_d = mem_q[head_q];
            head_d  = next_ptr(head_q);
            count_d = count_q - CW'(1);
          end
        end
        2'b11: begin
          // The read frees a slot this cycle, so a full queue can still accept the write.
          if (empty) begin
            z_out_d = z_in;
          end else begin
            z_out_d = mem_q[head_q];
            wr_en   = 1'b1;
            head_d  = next_ptr(head_q);
            tail_d  = next_ptr(tail_q);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      z_out_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      z_out_q     <= z_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_q[tail_q] <= z_in;
    end
  end

endmodule

// File: tb/tb_z_staging_queue.sv
// Bench for z_staging_queue: DEPTH=4 and DEPTH=1 instances share stimulus and are
// checked every cycle against a queue-based model, plus literal pins on directed steps.
module tb_z_staging_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  ctrl = 2'b00;
  logic [31:0] zin = '0;

  logic [31:0] a_out, b_out;
  logic [2:0]  a_cnt;
  logic [0:0]  b_cnt;
  logic        a_full, a_empty, a_ovf, a_unf;
  logic        b_full, b_empty, b_ovf, b_unf;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  typedef logic [31:0] q_t[$];
  q_t          mq [2];
  logic [31:0] m_out [2];
  bit          m_ovf [2];
  bit          m_unf [2];

  always #5 clk = ~clk;

  z_staging_queue #(.WIDTH(32), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .z_ctrl(ctrl), .z_in(zin), .flush(flush),
    .z_out(a_out), .count(a_cnt), .full(a_full), .empty(a_empty),
    .overflow(a_ovf), .underflow(a_unf)
  );

  z_staging_queue #(.WIDTH(32), .DEPTH(1)) dut_b (
    .clk(clk), .rst(rst), .z_ctrl(ctrl), .z_in(zin), .flush(flush),
    .z_out(b_out), .count(b_cnt), .full(b_full), .empty(b_empty),
    .overflow(b_ovf), .underflow(b_unf)
  );

  task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue per instance, updated from the command rules.
  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        int d;
        d = (i == 0) ? 4 : 1;
        if (rst) begin
          mq[i].delete(); m_out[i] = '0; m_ovf[i] = 0; m_unf[i] = 0;
        end else if (flush) begin
          mq[i].delete(); m_ovf[i] = 0; m_unf[i] = 0;
        end else begin
          case (ctrl)
            2'b10: if (mq[i].size() == d) m_ovf[i] = 1; else mq[i].push_back(zin);
            2'b01: if (mq[i].size() == 0) m_unf[i] = 1; else m_out[i] = mq[i].pop_front();
            2'b11: if (mq[i].size() == 0) m_out[i] = zin;
                   else begin m_out[i] = mq[i].pop_front(); mq[i].push_back(zin); end
            default: ;
          endcase
        end
      end
    end
  end

  // Compare process: every cycle once reset has been applied.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        pin("a.z_out",     a_out,           m_out[0]);
        pin("a.count",     32'(a_cnt),      32'(mq[0].size()));
        pin("a.full",      32'(a_full),     32'(mq[0].size() == 4));
        pin("a.empty",     32'(a_empty),    32'(mq[0].size() == 0));
        pin("a.overflow",  32'(a_ovf),      32'(m_ovf[0]));
        pin("a.underflow", 32'(a_unf),      32'(m_unf[0]));
        pin("b.z_out",     b_out,           m_out[1]);
        pin("b.count",     32'(b_cnt),      32'(mq[1].size()));
        pin("b.full",      32'(b_full),     32'(mq[1].size() == 1));
        pin("b.empty",     32'(b_empty),    32'(mq[1].size() == 0));
        pin("b.overflow",  32'(b_ovf),      32'(m_ovf[1]));
        pin("b.underflow", 32'(b_unf),      32'(m_unf[1]));
      end
    end
  end

  task automatic step(input logic r, input logic f, input logic [1:0] c, input logic [31:0] z);
    @(negedge clk);
    rst = r; flush = f; ctrl = c; zin = z;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with a capture pending: capture must be lost.
    step(1, 0, 2'b10, 32'hDEADBEEF);
    step(1, 0, 2'b10, 32'hDEADBEEF);
    chk_en = 1'b1;
    pin("rst.z_out", a_out, 32'h0);
    pin("rst.count", 32'(a_cnt), 0);
    pin("rst.empty", 32'(a_empty), 1);
    pin("rst.full", 32'(a_full), 0);
    pin("rst.flags", {30'b0, a_ovf, a_unf}, 0);
    repeat (3) step(0, 0, 2'b00, 32'h12345678);
    pin("idle.count", 32'(a_cnt), 0);
    pin("idle.z_out", a_out, 32'h0);

    // FIFO order with wrap
    step(0, 0, 2'b10, 32'h11); step(0, 0, 2'b10, 32'h22);
    step(0, 0, 2'b10, 32'h33); step(0, 0, 2'b10, 32'h44);
    pin("fill.full", 32'(a_full), 1);
    pin("fill.count", 32'(a_cnt), 4);
    step(0, 0, 2'b01, 0); pin("exp1", a_out, 32'h11);
    step(0, 0, 2'b01, 0); pin("exp2", a_out, 32'h22);
    pin("exp2.count", 32'(a_cnt), 2);
    step(0, 0, 2'b10, 32'h55); step(0, 0, 2'b10, 32'h66);
    pin("wrap.count", 32'(a_cnt), 4);
    step(0, 0, 2'b10, 32'h77);
    pin("ovf.flag", 32'(a_ovf), 1);
    pin("ovf.count", 32'(a_cnt), 4);
    step(0, 0, 2'b01, 0); pin("exp3", a_out, 32'h33);
    step(0, 0, 2'b01, 0); pin("exp4", a_out, 32'h44);
    step(0, 0, 2'b01, 0); pin("exp5", a_out, 32'h55);
    step(0, 0, 2'b01, 0); pin("exp6", a_out, 32'h66);
    pin("drain.empty", 32'(a_empty), 1);
    step(0, 0, 2'b01, 0);
    pin("unf.flag", 32'(a_unf), 1);
    pin("unf.z_out", a_out, 32'h66);
    pin("unf.ovf_sticky", 32'(a_ovf), 1);
    step(0, 1, 2'b00, 0);
    pin("flush.flags", {30'b0, a_ovf, a_unf}, 0);
    pin("flush.count", 32'(a_cnt), 0);

    // Simultaneous capture+expose
    step(0, 0, 2'b11, 32'hA5);
    pin("byp.z_out", a_out, 32'hA5);
    pin("byp.count", 32'(a_cnt), 0);
    step(0, 0, 2'b10, 1); step(0, 0, 2'b10, 2);
    step(0, 0, 2'b10, 3); step(0, 0, 2'b10, 4);
    step(0, 0, 2'b11, 5);
    pin("ce.z_out", a_out, 1);
    pin("ce.count", 32'(a_cnt), 4);
    pin("ce.ovf", 32'(a_ovf), 0);
    for (int k = 2; k <= 5; k++) begin
      step(0, 0, 2'b01, 0);
      pin($sformatf("ce.exp%0d", k), a_out, 32'(k));
    end

    // Mid-stream flush with a capture on the same edge
    step(0, 0, 2'b10, 32'h11); step(0, 0, 2'b10, 32'h22);
    step(0, 0, 2'b01, 0); step(0, 0, 2'b01, 0);
    step(0, 0, 2'b10, 32'h33); step(0, 0, 2'b10, 32'h44); step(0, 0, 2'b10, 32'h55);
    pin("pre.count", 32'(a_cnt), 3);
    pin("pre.z_out", a_out, 32'h22);
    step(0, 1, 2'b10, 32'h99);
    pin("mflush.count", 32'(a_cnt), 0);
    pin("mflush.z_out", a_out, 32'h22);
    pin("mflush.ovf", 32'(a_ovf), 0);
    step(0, 0, 2'b01, 0);
    pin("mflush.absent", a_out, 32'h22);
    pin("mflush.unf", 32'(a_unf), 1);

    // Mid-stream reset
    step(0, 0, 2'b10, 32'h33); step(0, 0, 2'b10, 32'h44); step(0, 0, 2'b10, 32'h55);
    step(1, 0, 2'b10, 32'h99);
    pin("mrst.count", 32'(a_cnt), 0);
    pin("mrst.z_out", a_out, 32'h0);
    pin("mrst.unf", 32'(a_unf), 0);

    // Single-entry instance behaviour
    step(0, 0, 2'b10, 32'h1234);
    pin("d1.full", 32'(b_full), 1);
    step(0, 0, 2'b01, 0);
    pin("d1.z_out", b_out, 32'h1234);
    step(0, 0, 2'b10, 32'hAAAA);
    step(0, 0, 2'b10, 32'hBBBB);
    pin("d1.ovf", 32'(b_ovf), 1);
    step(0, 0, 2'b01, 0);
    pin("d1.keep_first", b_out, 32'hAAAA);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic r, f;
      r = ($urandom_range(0, 99) == 0);
      f = ($urandom_range(0, 39) == 0);
      step(r, f, 2'($urandom_range(0, 3)), $urandom);
    end

    step(0, 0, 2'b00, 0);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/z_staging_queue.md
# z_staging_queue

Parametrised successor to the single-entry Z result register. It buffers up to DEPTH datapath results (ALU/Z values) in FIFO order and publishes them one at a time to a registered output under the same 2-bit capture/expose control encoding. It adds a simultaneous capture+expose mode, an empty-queue bypass, flush, occupancy reporting and sticky error flags. It sits between the ALU result bus and the processor's Z operand consumers.

## Interface
- WIDTH, 32, data width in bits (>=1)
- DEPTH, 4, number of buffered entries (>=1; need not be a power of two)
- CW, $clog2(DEPTH+1), derived width of count; not overridden by users
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- z_ctrl  input  2  00 idle, 10 capture, 01 expose, 11 capture+expose
- z_in  input  WIDTH  data to capture
- flush  input  1  discard all buffered entries
- z_out  output  WIDTH  registered published value
- count  output  CW  number of buffered entries, 0..DEPTH
- full  output  1  count == DEPTH, combinational from count
- empty  output  1  count == 0, combinational from count
- overflow  output  1  sticky: a capture was dropped
- underflow  output  1  sticky: an expose was issued on an empty queue

## Operation
- Storage: circular array of DEPTH entries with a head (read) pointer and a tail (write) pointer. Each pointer wraps from DEPTH-1 to 0 explicitly, with no reliance on power-of-two wrap.
- Priority on each edge: rst, then flush, then z_ctrl.
- rst: z_out=0, count=0, head=tail=0, overflow=0, underflow=0. Storage array is not reset; its contents are unobservable until written.
- flush (rst=0): count=0, head=tail=0, overflow=0, underflow=0. z_out holds its value. z_ctrl is ignored that cycle.
- 00: no state change.
- 10 capture:
  - not full: mem[tail]=z_in, tail advances, count+1.
  - full: z_in dropped, overflow=1, all else unchanged.
- 01 expose:
  - not empty: z_out=mem[head], head advances, count-1.
  - empty: z_out holds, underflow=1.
- 11 capture+expose:
  - empty: bypass, z_out=z_in. count stays 0, pointers unchanged, no flag set.
  - not empty (including full): z_out=mem[head], mem[tail]=z_in, both pointers advance, count unchanged, overflow not set. The full case is legal because the read frees a slot in the same cycle.
- With DEPTH=1, a 10 followed by 01 reproduces the single-entry register behaviour.
- Sticky flags clear only on rst or flush.

## Timing
- All outputs except full and empty are registered. full and empty follow count within the same cycle.
- Capture latency: an entry captured at edge N can be exposed at edge N+1 at the earliest. z_out shows it after edge N+1.
- Bypass latency: with 11 on an empty queue, z_in appears on z_out after that same edge.
- count, full and empty reflect the post-edge state. Upstream must sample full before issuing 10 to avoid a drop.
- A flush or rst asserted mid-stream takes effect at that edge. Entries in flight are discarded, and any capture on that cycle is lost without setting overflow.
- Overflow and underflow rise on the edge of the offending command and stay high.

## Test plan
- Reset/idle: assert rst for 2 cycles with z_ctrl=10, z_in=0xDEADBEEF. Required: z_out=0, count=0, empty=1, full=0, both flags 0. Then hold 00 for 3 cycles: no change.
- FIFO order with wrap (DEPTH=4):
  - capture 0x11, 0x22, 0x33, 0x44 -> full=1, count=4.
  - expose twice -> z_out 0x11 then 0x22, count=2.
  - capture 0x55, 0x66 -> count=4, pointers wrapped.
  - expose four times -> 0x33, 0x44, 0x55, 0x66, then empty=1.
- Errors:
  - on a full queue, capture 0x77 -> overflow=1, count stays 4, the later expose sequence excludes 0x77.
  - on an empty queue, expose -> underflow=1, z_out unchanged.
  - flush -> both flags 0, count=0.
- Simultaneous 11:
  - empty queue, z_in=0xA5 -> z_out=0xA5, count=0.
  - full queue [1,2,3,4], z_in=5 -> z_out=1, count=4, no overflow, subsequent exposes yield 2, 3, 4, 5.
- Mid-operation flush/reset:
  - with count=3 and z_out=0x22, assert flush together with z_ctrl=10 -> count=0, z_out=0x22, captured value absent.
  - repeat with rst instead of flush -> z_out=0.
- DEPTH=1 build: capture 0x1234, then expose -> z_out=0x1234. A second capture before the expose -> overflow=1.
